// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall sequencing, taken-branch flush
// sequencing, EX operand forwarding selects and a saturating stall-cycle counter.
module hazard_control_unit #(
   parameter int REG_AW     = 5,
   parameter int LOAD_LAT   = 1,
   parameter int BR_PENALTY = 1,
   parameter int CNT_W      = 16
) (
   input  logic              Clk_i,
   input  logic              Rst_ni,
   input  logic              ID_EX_MemRead_i,
   input  logic              ID_EX_RegWrite_i,
   input  logic              EX_MEM_RegWrite_i,
   input  logic              MEM_WB_RegWrite_i,
   input  logic [REG_AW-1:0] IF_ID_Rs_i,
   input  logic [REG_AW-1:0] IF_ID_Rt_i,
   input  logic [REG_AW-1:0] ID_EX_Rs_i,
   input  logic [REG_AW-1:0] ID_EX_Rt_i,
   input  logic [REG_AW-1:0] ID_EX_Rd_i,
   input  logic [REG_AW-1:0] EX_MEM_Rd_i,
   input  logic [REG_AW-1:0] MEM_WB_Rd_i,
   input  logic              BranchTaken_i,
   input  logic              ClrCount_i,
   output logic              PCWrite_o,
   output logic              IF_ID_Write_o,
   output logic              ID_EX_Bubble_o,
   output logic              IF_Flush_o,
   output logic [1:0]        ForwardA_o,
   output logic [1:0]        ForwardB_o,
   output logic [CNT_W-1:0]  StallCount_o
);

   // state  | meaning
   // IDLE   | normal flow; first stall or first flush cycle is decided here
   // LSTALL | remaining load-use stall cycles (LOAD_LAT > 1 only)
   // FLUSH  | remaining branch flush cycles (BR_PENALTY > 1 only)
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   // The IDLE cycle already supplies one stall/flush cycle, so the extra
   // phase only needs the remaining count.
   localparam logic [2:0] LSTALL_INIT = 3'(LOAD_LAT - 1);
   localparam logic [2:0] FLUSH_INIT  = 3'(BR_PENALTY - 1);

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             load_use_hit;
   logic             stall_raw, flush_raw;
   logic             stall_act, flush_act;

   // Register 0 is hardwired, so a zero destination never hazards.
   assign load_use_hit = ID_EX_MemRead_i && ID_EX_RegWrite_i && (ID_EX_Rd_i != '0) &&
                         ((ID_EX_Rd_i == IF_ID_Rs_i) || (ID_EX_Rd_i == IF_ID_Rt_i));

   // Next-state and combinational stall/flush decode; stall beats branch in IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
      flush_raw = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_use_hit) begin
               stall_raw = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = LSTALL;
                  cnt_d   = LSTALL_INIT;
               end
            end else if (BranchTaken_i) begin
               flush_raw = 1'b1;
               if (BR_PENALTY > 1) begin
                  state_d = FLUSH;
                  cnt_d   = FLUSH_INIT;
               end
            end
         end
         LSTALL: begin
            stall_raw = 1'b1;
            if (cnt_q <= 3'd1) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         FLUSH: begin
            flush_raw = 1'b1;
            if (cnt_q <= 3'd1) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Reset forces pass-through outputs even if the inputs describe a hazard.
   assign stall_act = stall_raw & Rst_ni;
   assign flush_act = flush_raw & Rst_ni;

   assign PCWrite_o      = ~stall_act;
   assign IF_ID_Write_o  = ~stall_act;
   assign ID_EX_Bubble_o = stall_act;
   assign IF_Flush_o     = flush_act;

   // EX operand select: EX_MEM result is newer, so it wins over MEM_WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (EX_MEM_RegWrite_i && (EX_MEM_Rd_i != '0) && (EX_MEM_Rd_i == src))
         return 2'b10;
      else if (MEM_WB_RegWrite_i && (MEM_WB_Rd_i != '0) && (MEM_WB_Rd_i == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign ForwardA_o = Rst_ni ? fwd_sel(ID_EX_Rs_i) : 2'b00;
   assign ForwardB_o = Rst_ni ? fwd_sel(ID_EX_Rt_i) : 2'b00;

   // Stall-cycle counter: clear beats increment, saturates at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ClrCount_i)
         stall_cnt_d = '0;
      else if (stall_act && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   assign StallCount_o = stall_cnt_q;

   // State, sequence counter and stall counter registers.
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three instances with different latencies,
// penalties and counter widths, checked against a cycle-count reference model.
module tb_hazard_control_unit;

   logic       Clk = 1'b0;
   logic       rst_n;
   logic       memread, idex_rw, exmem_rw, memwb_rw, br, clr;
   logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;

   logic       pcw [3];
   logic       ifw [3];
   logic       bub [3];
   logic       flo [3];
   logic [1:0] fa  [3];
   logic [1:0] fb  [3];
   logic [15:0] sc0, sc1;
   logic [2:0]  sc2;

   int vectors    = 0;
   int miscompares = 0;

   int lat  [3] = '{1, 3, 4};
   int pen  [3] = '{1, 2, 3};
   int cmax [3] = '{65535, 65535, 7};

   // model: remaining stall cycles after the current one, remaining flush
   // cycles after the current one, and the stall count
   int m_stall [3];
   int m_flush [3];
   int m_cnt   [3];

   always #5 Clk = ~Clk;

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(1), .BR_PENALTY(1), .CNT_W(16)) u0 (
      .Clk_i(Clk), .Rst_ni(rst_n),
      .ID_EX_MemRead_i(memread), .ID_EX_RegWrite_i(idex_rw),
      .EX_MEM_RegWrite_i(exmem_rw), .MEM_WB_RegWrite_i(memwb_rw),
      .IF_ID_Rs_i(ifid_rs), .IF_ID_Rt_i(ifid_rt),
      .ID_EX_Rs_i(idex_rs), .ID_EX_Rt_i(idex_rt), .ID_EX_Rd_i(idex_rd),
      .EX_MEM_Rd_i(exmem_rd), .MEM_WB_Rd_i(memwb_rd),
      .BranchTaken_i(br), .ClrCount_i(clr),
      .PCWrite_o(pcw[0]), .IF_ID_Write_o(ifw[0]), .ID_EX_Bubble_o(bub[0]),
      .IF_Flush_o(flo[0]), .ForwardA_o(fa[0]), .ForwardB_o(fb[0]),
      .StallCount_o(sc0));

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(3), .BR_PENALTY(2), .CNT_W(16)) u1 (
      .Clk_i(Clk), .Rst_ni(rst_n),
      .ID_EX_MemRead_i(memread), .ID_EX_RegWrite_i(idex_rw),
      .EX_MEM_RegWrite_i(exmem_rw), .MEM_WB_RegWrite_i(memwb_rw),
      .IF_ID_Rs_i(ifid_rs), .IF_ID_Rt_i(ifid_rt),
      .ID_EX_Rs_i(idex_rs), .ID_EX_Rt_i(idex_rt), .ID_EX_Rd_i(idex_rd),
      .EX_MEM_Rd_i(exmem_rd), .MEM_WB_Rd_i(memwb_rd),
      .BranchTaken_i(br), .ClrCount_i(clr),
      .PCWrite_o(pcw[1]), .IF_ID_Write_o(ifw[1]), .ID_EX_Bubble_o(bub[1]),
      .IF_Flush_o(flo[1]), .ForwardA_o(fa[1]), .ForwardB_o(fb[1]),
      .StallCount_o(sc1));

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(4), .BR_PENALTY(3), .CNT_W(3)) u2 (
      .Clk_i(Clk), .Rst_ni(rst_n),
      .ID_EX_MemRead_i(memread), .ID_EX_RegWrite_i(idex_rw),
      .EX_MEM_RegWrite_i(exmem_rw), .MEM_WB_RegWrite_i(memwb_rw),
      .IF_ID_Rs_i(ifid_rs), .IF_ID_Rt_i(ifid_rt),
      .ID_EX_Rs_i(idex_rs), .ID_EX_Rt_i(idex_rt), .ID_EX_Rd_i(idex_rd),
      .EX_MEM_Rd_i(exmem_rd), .MEM_WB_Rd_i(memwb_rd),
      .BranchTaken_i(br), .ClrCount_i(clr),
      .PCWrite_o(pcw[2]), .IF_ID_Write_o(ifw[2]), .ID_EX_Bubble_o(bub[2]),
      .IF_Flush_o(flo[2]), .ForwardA_o(fa[2]), .ForwardB_o(fb[2]),
      .StallCount_o(sc2));

   // ---------------- reference model ----------------
   function automatic logic hit();
      return memread && idex_rw && (idex_rd != 5'd0) &&
             ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
   endfunction

   function automatic logic [1:0] fwd(input logic [4:0] src);
      if (!rst_n) return 2'b00;
      if (exmem_rw && exmem_rd != 5'd0 && exmem_rd == src) return 2'b10;
      if (memwb_rw && memwb_rd != 5'd0 && memwb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   // {PCWrite, Bubble, Flush}
   function automatic logic [2:0] exp_ctl(input int k);
      if (!rst_n)         return 3'b100;
      if (m_stall[k] > 0) return 3'b010;
      if (m_flush[k] > 0) return 3'b101;
      if (hit())          return 3'b010;
      if (br)             return 3'b101;
      return 3'b100;
   endfunction

   function automatic logic [7:0] exp_vec(input int k);
      logic [2:0] c;
      c = exp_ctl(k);
      return {c[2], c[2], c[1], c[0], fwd(idex_rs), fwd(idex_rt)};
   endfunction

   function automatic logic [7:0] got_vec(input int k);
      return {pcw[k], ifw[k], bub[k], flo[k], fa[k], fb[k]};
   endfunction

   function automatic int got_sc(input int k);
      if (k == 0) return int'(sc0);
      if (k == 1) return int'(sc1);
      return int'(sc2);
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         m_stall[k] = 0; m_flush[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic m_advance();
      logic [2:0] c;
      for (int k = 0; k < 3; k++) begin
         c = exp_ctl(k);
         if (!rst_n) begin
            m_stall[k] = 0; m_flush[k] = 0; m_cnt[k] = 0;
         end else begin
            if (clr) m_cnt[k] = 0;
            else if (!c[2] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (m_stall[k] > 0)      m_stall[k]--;
            else if (m_flush[k] > 0) m_flush[k]--;
            else if (hit())          m_stall[k] = lat[k] - 1;
            else if (br)             m_flush[k] = pen[k] - 1;
         end
      end
   endtask

   // called at the negative edge, returns one step after the next rising edge
   task automatic cycle_end();
      m_advance();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      memread = 0; idex_rw = 0; exmem_rw = 0; memwb_rw = 0; br = 0; clr = 0;
      ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0; idex_rd = 0;
      exmem_rd = 0; memwb_rd = 0;
   endtask

   task automatic set_hit();
      memread = 1; idex_rw = 1; idex_rd = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      m_reset();
      @(posedge Clk);
      #1;
      rst_n = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      set_hit();
      br = 1; exmem_rw = 1; exmem_rd = 5'd2; idex_rs = 5'd2; idex_rt = 5'd2;
      rst_n = 0;
      m_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_vec(k) !== 8'b1100_0000) begin
            miscompares++;
            $display("FAIL reset_outputs u%0d got %b want %b", k, got_vec(k), 8'b1100_0000);
         end
         vectors++;
         if (got_sc(k) != 0) begin
            miscompares++;
            $display("FAIL reset_count u%0d got %0d want 0", k, got_sc(k));
         end
      end
      @(posedge Clk);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_vec(k) !== exp_vec(k)) begin
            miscompares++;
            $display("FAIL reset_held u%0d got %b want %b", k, got_vec(k), exp_vec(k));
         end
      end
      do_reset();
   endtask

   task automatic test_load_use();
      int stalls [3];
      do_reset();
      for (int k = 0; k < 3; k++) stalls[k] = 0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         if (c == 0) set_hit();
         if (c == 1) br = 1;
         @(negedge Clk);
         for (int k = 0; k < 3; k++) begin
            if (pcw[k] === 1'b0) stalls[k]++;
            vectors++;
            if (got_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL load_use u%0d cyc%0d got %b want %b", k, c, got_vec(k), exp_vec(k));
            end
         end
         if (c == 1) begin
            vectors++;
            if (flo[1] !== 1'b0 || flo[2] !== 1'b0) begin
               miscompares++;
               $display("FAIL branch_in_stall flush u1=%b u2=%b want 0", flo[1], flo[2]);
            end
         end
         cycle_end();
      end
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (stalls[k] != lat[k]) begin
            miscompares++;
            $display("FAIL stall_len u%0d got %0d want %0d", k, stalls[k], lat[k]);
         end
         vectors++;
         if (got_sc(k) != lat[k]) begin
            miscompares++;
            $display("FAIL stall_count u%0d got %0d want %0d", k, got_sc(k), lat[k]);
         end
      end
      cycle_end();
   endtask

   task automatic test_zero_reg();
      do_reset();
      memread = 1; idex_rw = 1; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
      exmem_rw = 1; exmem_rd = 0; idex_rs = 0; idex_rt = 0;
      memwb_rw = 1; memwb_rd = 0;
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_vec(k) !== 8'b1100_0000) begin
            miscompares++;
            $display("FAIL zero_reg u%0d got %b want %b", k, got_vec(k), 8'b1100_0000);
         end
      end
      cycle_end();
      idle_inputs();
   endtask

   task automatic test_forward();
      idle_inputs();
      exmem_rw = 1; memwb_rw = 1; exmem_rd = 5'd5; memwb_rd = 5'd5;
      idex_rs = 5'd5; idex_rt = 5'd5;
      #1;
      vectors++;
      if (fa[0] !== 2'b10 || fb[0] !== 2'b10) begin
         miscompares++;
         $display("FAIL fwd_exmem got A=%b B=%b want 10/10", fa[0], fb[0]);
      end
      exmem_rw = 0;
      #1;
      vectors++;
      if (fa[0] !== 2'b01 || fb[0] !== 2'b01) begin
         miscompares++;
         $display("FAIL fwd_memwb got A=%b B=%b want 01/01", fa[0], fb[0]);
      end
      for (int i = 0; i < 60; i++) begin
         exmem_rw = 1'($urandom_range(0, 1));
         memwb_rw = 1'($urandom_range(0, 1));
         exmem_rd = 5'($urandom_range(0, 3));
         memwb_rd = 5'($urandom_range(0, 3));
         idex_rs  = 5'($urandom_range(0, 3));
         idex_rt  = 5'($urandom_range(0, 3));
         #1;
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL fwd_rand u%0d i%0d got %b want %b", k, i, got_vec(k), exp_vec(k));
            end
         end
      end
      idle_inputs();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_branch();
      int flushes [3];
      do_reset();
      for (int k = 0; k < 3; k++) flushes[k] = 0;
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         if (c == 0) br = 1;
         @(negedge Clk);
         for (int k = 0; k < 3; k++) begin
            if (flo[k] === 1'b1) flushes[k]++;
            vectors++;
            if (got_vec(k) !== exp_vec(k) || pcw[k] !== 1'b1) begin
               miscompares++;
               $display("FAIL branch u%0d cyc%0d got %b want %b", k, c, got_vec(k), exp_vec(k));
            end
         end
         cycle_end();
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (flushes[k] != pen[k]) begin
            miscompares++;
            $display("FAIL flush_len u%0d got %0d want %0d", k, flushes[k], pen[k]);
         end
      end
      idle_inputs();
      set_hit();
      br = 1;
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (flo[k] !== 1'b0 || pcw[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_beats_branch u%0d got flush=%b pcw=%b want 0/0", k, flo[k], pcw[k]);
         end
      end
      cycle_end();
      idle_inputs();
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL branch_drain u%0d cyc%0d got %b want %b", k, c, got_vec(k), exp_vec(k));
            end
         end
         cycle_end();
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_hit();
      @(negedge Clk);
      cycle_end();
      idle_inputs();
      rst_n = 0;
      m_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_vec(k) !== 8'b1100_0000 || got_sc(k) != 0) begin
            miscompares++;
            $display("FAIL reset_mid_stall u%0d got %b cnt %0d want %b cnt 0",
                     k, got_vec(k), got_sc(k), 8'b1100_0000);
         end
      end
      @(posedge Clk);
      #1;
      rst_n = 1;
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_vec(k) !== 8'b1100_0000) begin
            miscompares++;
            $display("FAIL after_reset_idle u%0d got %b want %b", k, got_vec(k), 8'b1100_0000);
         end
      end
      cycle_end();
   endtask

   task automatic test_clr_count();
      do_reset();
      set_hit();
      @(negedge Clk);
      cycle_end();
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         cycle_end();
      end
      set_hit();
      clr = 1;
      @(negedge Clk);
      cycle_end();
      idle_inputs();
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_sc(k) != 0) begin
            miscompares++;
            $display("FAIL clr_beats_inc u%0d got %0d want 0", k, got_sc(k));
         end
      end
      cycle_end();
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         cycle_end();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_hit();
      for (int c = 0; c < 12; c++) begin
         @(negedge Clk);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_vec(k) !== exp_vec(k) || got_sc(k) != m_cnt[k]) begin
               miscompares++;
               $display("FAIL saturate u%0d cyc%0d got %b/%0d want %b/%0d",
                        k, c, got_vec(k), got_sc(k), exp_vec(k), m_cnt[k]);
            end
         end
         cycle_end();
      end
      @(negedge Clk);
      vectors++;
      if (got_sc(0) != 12 || got_sc(1) != 12 || got_sc(2) != 7) begin
         miscompares++;
         $display("FAIL saturate_final got %0d/%0d/%0d want 12/12/7", got_sc(0), got_sc(1), got_sc(2));
      end
      idle_inputs();
      cycle_end();
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         memread  = ($urandom_range(0, 99) < 35);
         idex_rw  = ($urandom_range(0, 99) < 80);
         exmem_rw = 1'($urandom_range(0, 1));
         memwb_rw = 1'($urandom_range(0, 1));
         br       = ($urandom_range(0, 99) < 25);
         clr      = ($urandom_range(0, 99) < 3);
         ifid_rs  = 5'($urandom_range(0, 3));
         ifid_rt  = 5'($urandom_range(0, 3));
         idex_rs  = 5'($urandom_range(0, 3));
         idex_rt  = 5'($urandom_range(0, 3));
         idex_rd  = 5'($urandom_range(0, 3));
         exmem_rd = 5'($urandom_range(0, 3));
         memwb_rd = 5'($urandom_range(0, 3));
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 99) < 1) begin
            rst_n = 0;
            m_reset();
         end
         @(negedge Clk);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL random_ctl u%0d i%0d got %b want %b", k, i, got_vec(k), exp_vec(k));
            end
            vectors++;
            if (got_sc(k) != m_cnt[k]) begin
               miscompares++;
               $display("FAIL random_cnt u%0d i%0d got %0d want %0d", k, i, got_sc(k), m_cnt[k]);
            end
         end
         cycle_end();
      end
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      m_reset();
      @(posedge Clk);
      #1;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_forward();
      test_branch();
      test_reset_mid_stall();
      test_clr_count();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout after %0d vectors", vectors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_AW, default 5, SHALL set the register-specifier width.
REQ-002 Parameter LOAD_LAT, default 1, range 1..4, SHALL set total stall cycles per load-use hazard.
REQ-003 Parameter BR_PENALTY, default 1, range 1..3, SHALL set the number of cycles IF_Flush is asserted per taken branch.
REQ-004 Parameter CNT_W, default 16, SHALL set the StallCount width.
REQ-005 Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-low.
REQ-007 ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite  in  1 each  stage control bits.
REQ-008 IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd  in  REG_AW each  register specifiers; ID_EX_Rd is the already-muxed destination.
REQ-009 BranchTaken  in  1  branch resolved taken in ID this cycle.
REQ-010 ClrCount  in  1  synchronous clear of StallCount.
REQ-011 PCWrite, IF_ID_Write  out  1 each  1 = advance PC / IF_ID.
REQ-012 ID_EX_Bubble  out  1  1 = load zeros into ID_EX control.
REQ-013 IF_Flush  out  1  1 = zero the IF_ID instruction.
REQ-014 ForwardA, ForwardB  out  2 each  EX operand select: 00 regfile, 10 EX_MEM, 01 MEM_WB.
REQ-015 StallCount  out  CNT_W  count of cycles with PCWrite=0.

Function
REQ-016 Register specifier 0 SHALL never create a hazard or forward.
REQ-017 Load-use hit = ID_EX_MemRead & ID_EX_RegWrite & ID_EX_Rd!=0 & (ID_EX_Rd==IF_ID_Rs | ID_EX_Rd==IF_ID_Rt).
REQ-018 FSM states SHALL be IDLE, LSTALL, FLUSH.
REQ-019 In IDLE on load-use hit, outputs SHALL be PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 combinationally in the same cycle; if LOAD_LAT>1, next state LSTALL with counter loaded to LOAD_LAT-1.
REQ-020 In LSTALL, the same stall outputs SHALL hold; counter decrements each cycle; at counter==1, next state IDLE; total stalled cycles SHALL equal LOAD_LAT exactly.
REQ-021 In IDLE with no load-use hit and BranchTaken=1, IF_Flush SHALL be 1 that cycle (PC/IF_ID still written); if BR_PENALTY>1, next state FLUSH for BR_PENALTY-1 further flush cycles, then IDLE.
REQ-022 Load-use hit and BranchTaken in the same cycle: stall SHALL win, branch SHALL be ignored (re-presented by the held ID stage after the stall).
REQ-023 BranchTaken and load-use hits SHALL be ignored in LSTALL and FLUSH; no state SHALL be re-entered until IDLE is reached.
REQ-024 ForwardA SHALL be 10 if EX_MEM_RegWrite & EX_MEM_Rd!=0 & EX_MEM_Rd==ID_EX_Rs; else 01 if MEM_WB_RegWrite & MEM_WB_Rd!=0 & MEM_WB_Rd==ID_EX_Rs; else 00; ForwardB identical using ID_EX_Rt; EX_MEM SHALL take priority over MEM_WB.
REQ-025 Forwarding SHALL be purely combinational and independent of FSM state.
REQ-026 StallCount SHALL increment by 1 each cycle PCWrite=0, saturate at all-ones, and clear to 0 on ClrCount=1 (clear beats increment).
REQ-027 In IDLE with no hits: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_Flush=0.

Reset
REQ-028 Rst=0 SHALL immediately force state IDLE, stall/flush counters 0, and StallCount 0, regardless of Clk.
REQ-029 While Rst=0, outputs SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_Flush=0, ForwardA=ForwardB=00.
REQ-030 Rst asserted mid-LSTALL or mid-FLUSH SHALL abort the sequence; after release the FSM SHALL start in IDLE.

Verification
REQ-031 LOAD_LAT=1: ID_EX_MemRead=1, ID_EX_RegWrite=1, ID_EX_Rd=8, IF_ID_Rs=8 for one cycle -> PCWrite=0, Bubble=1 for exactly 1 cycle; StallCount=1.
REQ-032 LOAD_LAT=3: same hit -> PCWrite=0 for exactly 3 consecutive cycles, then 1; StallCount=3; a BranchTaken pulse in cycle 2 produces no IF_Flush.
REQ-033 ID_EX_Rd=0 with MemRead=1 and IF_ID_Rs=0 -> no stall; EX_MEM_Rd=0 with ID_EX_Rs=0 -> ForwardA=00.
REQ-034 EX_MEM_Rd=MEM_WB_Rd=5, both RegWrite=1, ID_EX_Rs=5, ID_EX_Rt=5 -> ForwardA=ForwardB=10; drop EX_MEM_RegWrite -> both 01.
REQ-035 BR_PENALTY=2: BranchTaken=1 with no hit -> IF_Flush=1 for 2 cycles, PCWrite stays 1; same cycle as load-use hit -> stall only, IF_Flush=0.
REQ-036 Rst=0 asserted in 2nd cycle of LOAD_LAT=4 stall -> outputs return to pass values immediately, StallCount=0; ClrCount with concurrent stall -> StallCount=0 next edge.
